mfp_7seg_scanner: RTL and testbench

Time-multiplexed seven-segment display driver; consumer side of the 32-bit 7-segment GPIO register exported by the system GPIO map. It takes a packed hex value (one nibble per digit), per-digit enables and decimal points, and scans them onto common-anode displays. Each digit slot is preceded by an anti-ghosting blank interval. Inputs are snapshotted once per frame so that a write from the core cannot tear the displayed value.

---
 rtl/mfp_7seg_scanner_pkg.sv | 45 ++++
 rtl/mfp_7seg_scanner_if.sv | 29 ++
 rtl/mfp_hex_to_seg.sv | 16 +
 rtl/mfp_7seg_scanner.sv | 111 +++++++++++
 tb/tb_mfp_7seg_scanner.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfp_7seg_scanner_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mfp_7seg_pkg
// Description : Shared types, constants and the hex-to-segment decode used
//               by the seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package mfp_7seg_pkg;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low segment pattern, bit order g..a (seg[0] = a).
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      seg = SEG_OFF;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mfp_7seg_scanner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mfp_7seg_scanner_if
// Description : Display data in / segment and anode drive out bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mfp_7seg_scanner_if #(
   parameter int DIGIT_COUNT = 8
);
   logic [4*DIGIT_COUNT-1:0] value;
   logic [DIGIT_COUNT-1:0]   digit_en;
   logic [DIGIT_COUNT-1:0]   dots;
   logic [6:0]               seg_n;
   logic                     dp_n;
   logic [DIGIT_COUNT-1:0]   an_n;
   logic                     frame_done;

   modport master (
      output value, digit_en, dots,
      input  seg_n, dp_n, an_n, frame_done
   );

   modport slave (
      input  value, digit_en, dots,
      output seg_n, dp_n, an_n, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/mfp_hex_to_seg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mfp_hex_to_seg
// Description : Combinational nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_hex_to_seg
   import mfp_7seg_pkg::*;
(
   input  wire logic [3:0] i_nib,
   output logic      [6:0] o_seg
);
   assign o_seg = hex_to_seg(i_nib);
endmodule
`default_nettype wire

// File: rtl/mfp_7seg_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mfp_7seg_scanner
// Description : Time-multiplexed common-anode seven-segment scanner with
//               per-slot blanking and once-per-frame input snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_7seg_scanner
   import mfp_7seg_pkg::*;
#(
   parameter int DIGIT_COUNT  = 8,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   mfp_7seg_scanner_if.slave bus
);
   localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IW   = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

   localparam logic [CW-1:0] c_BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] c_SHOW_LAST  = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] c_IDX_LAST   = IW'(DIGIT_COUNT - 1);

   state_t                   r_state, w_state_nxt;
   logic [IW-1:0]            r_idx,   w_idx_nxt;
   logic [CW-1:0]            r_cnt,   w_cnt_nxt;
   logic                     w_load;
   logic [4*DIGIT_COUNT-1:0] r_val_s;
   logic [DIGIT_COUNT-1:0]   r_en_s;
   logic [DIGIT_COUNT-1:0]   r_dot_s;

   logic [3:0]               w_nib;
   logic [6:0]               w_seg;
   logic                     w_lit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_BLANK;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_val_s <= '0;
         r_en_s  <= '0;
         r_dot_s <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_load) begin
            r_val_s <= bus.value;
            r_en_s  <= bus.digit_en;
            r_dot_s <= bus.dots;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_load      = 1'b0;
      case (r_state)
         ST_BLANK: begin
            if (r_cnt == c_BLANK_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SHOW;
               // Snapshot only at the start of slot 0 so a frame never tears.
               w_load      = (r_idx == '0);
            end
         end
         ST_SHOW: begin
            if (r_cnt == c_SHOW_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_BLANK;
               w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_BLANK;
         end
      endcase
   end

   assign w_nib = r_val_s[4*int'(r_idx) +: 4];

   mfp_hex_to_seg u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   assign w_lit = (r_state == ST_SHOW) && r_en_s[r_idx];

   always_comb begin
      bus.an_n        = '1;
      bus.seg_n       = SEG_OFF;
      bus.dp_n        = 1'b1;
      if (w_lit) begin
         bus.an_n[r_idx] = 1'b0;
         bus.seg_n       = w_seg;
         bus.dp_n        = ~r_dot_s[r_idx];
      end
      bus.frame_done  = (r_state == ST_SHOW) && (r_idx == c_IDX_LAST)
                        && (r_cnt == c_SHOW_LAST);
   end

endmodule
`default_nettype wire

// File: tb/tb_mfp_7seg_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mfp_7seg_scanner
// Description : Directed self-checking bench, DIGIT_COUNT=8 PRESCALE=4 BLANK=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfp_7seg_scanner;
   localparam int DC = 8;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   cyc;

   logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   mfp_7seg_scanner_if #(.DIGIT_COUNT(DC)) bus ();

   mfp_7seg_scanner #(
      .DIGIT_COUNT  (DC),
      .PRESCALE     (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each slot is 6 cycles (2 blank + 4 lit), 48 per frame.
   function automatic logic [7:0] exp_an(int c, logic [7:0] en);
      logic [7:0] a;
      int d, ph;
      d  = (c % 48) / 6;
      ph = (c % 48) % 6;
      a  = 8'hFF;
      if (ph >= 2 && en[d]) a[d] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] exp_seg(int c, logic [31:0] v, logic [7:0] en);
      int d, ph;
      d  = (c % 48) / 6;
      ph = (c % 48) % 6;
      if (ph < 2 || !en[d]) return 7'h7F;
      return HEX[v[4*d +: 4]];
   endfunction

   function automatic logic exp_dp(int c, logic [7:0] en, logic [7:0] dt);
      int d, ph;
      d  = (c % 48) / 6;
      ph = (c % 48) % 6;
      if (ph < 2 || !en[d]) return 1'b1;
      return ~dt[d];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      bus.value    = 32'h76543210;
      bus.digit_en = 8'hFF;
      bus.dots     = 8'h00;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      n_vec++;
      if (bus.an_n !== 8'hFF || bus.seg_n !== 7'h7F || bus.dp_n !== 1'b1 || bus.frame_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: an_n=%h seg_n=%h dp_n=%b fd=%b, need FF 7F 1 0",
                  bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      while (cyc <= 8) begin
         logic [7:0] ea;
         logic [6:0] es;
         ea = (cyc < 2 || cyc > 5) ? 8'hFF : 8'hFE;
         es = (cyc < 2 || cyc > 5) ? 7'h7F : 7'h40;
         if (cyc == 8) begin ea = 8'hFD; es = 7'h79; end
         n_vec++;
         if (bus.an_n !== ea || bus.seg_n !== es) begin
            n_err++;
            $display("FAIL reset_release c%0d: an_n=%h seg_n=%h, need %h %h",
                     cyc, bus.an_n, bus.seg_n, ea, es);
         end
         step();
      end
   endtask

   task automatic test_full_frame();
      int fd_seen;
      fd_seen = 0;
      bus.value    = 32'h76543210;
      bus.digit_en = 8'hFF;
      bus.dots     = 8'h00;
      do_reset();
      while (cyc < 100) begin
         logic efd;
         efd = ((cyc % 48) == 47);
         if (bus.frame_done) fd_seen++;
         n_vec++;
         if (bus.frame_done !== efd) begin
            n_err++;
            $display("FAIL frame_done c%0d: got %b need %b", cyc, bus.frame_done, efd);
         end
         n_vec++;
         if (bus.an_n !== exp_an(cyc, 8'hFF) || bus.seg_n !== exp_seg(cyc, 32'h76543210, 8'hFF)) begin
            n_err++;
            $display("FAIL frame_scan c%0d: an_n=%h seg_n=%h, need %h %h", cyc,
                     bus.an_n, bus.seg_n, exp_an(cyc, 8'hFF), exp_seg(cyc, 32'h76543210, 8'hFF));
         end
         if (cyc == 47) begin
            n_vec++;
            if (bus.an_n !== 8'h7F || bus.seg_n !== 7'h78) begin
               n_err++;
               $display("FAIL digit7: an_n=%h seg_n=%h, need 7F 78", bus.an_n, bus.seg_n);
            end
         end
         step();
      end
      n_vec++;
      if (fd_seen != 2) begin
         n_err++;
         $display("FAIL frame_done_count: got %0d need 2", fd_seen);
      end
   endtask

   task automatic test_enables();
      bus.value    = 32'h76543210;
      bus.digit_en = 8'b0000_0101;
      bus.dots     = 8'h04;
      do_reset();
      while (cyc < 96) begin
         n_vec++;
         if (bus.an_n !== exp_an(cyc, 8'h05) || bus.seg_n !== exp_seg(cyc, 32'h76543210, 8'h05)
             || bus.dp_n !== exp_dp(cyc, 8'h05, 8'h04) || bus.frame_done !== ((cyc % 48) == 47)) begin
            n_err++;
            $display("FAIL enables c%0d: an_n=%h seg_n=%h dp_n=%b fd=%b, need %h %h %b %b", cyc,
                     bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done, exp_an(cyc, 8'h05),
                     exp_seg(cyc, 32'h76543210, 8'h05), exp_dp(cyc, 8'h05, 8'h04), (cyc % 48) == 47);
         end
         step();
      end
   endtask

   task automatic test_no_tear();
      bus.value    = 32'h76543210;
      bus.digit_en = 8'hFF;
      bus.dots     = 8'h00;
      do_reset();
      while (cyc < 96) begin
         logic [31:0] ev;
         if (cyc == 21) bus.value = 32'hFFFFFFFF;
         ev = (cyc < 48) ? 32'h76543210 : 32'hFFFFFFFF;
         n_vec++;
         if (bus.an_n !== exp_an(cyc, 8'hFF) || bus.seg_n !== exp_seg(cyc, ev, 8'hFF)) begin
            n_err++;
            $display("FAIL no_tear c%0d: an_n=%h seg_n=%h, need %h %h", cyc,
                     bus.an_n, bus.seg_n, exp_an(cyc, 8'hFF), exp_seg(cyc, ev, 8'hFF));
         end
         step();
      end
   endtask

   task automatic test_mid_reset();
      bus.value    = 32'h76543210;
      bus.digit_en = 8'hFF;
      bus.dots     = 8'hFF;
      do_reset();
      while (cyc < 33) step();
      n_vec++;
      if (bus.an_n !== 8'hDF || bus.seg_n !== 7'h12 || bus.dp_n !== 1'b0) begin
         n_err++;
         $display("FAIL pre_reset_d5: an_n=%h seg_n=%h dp_n=%b, need DF 12 0",
                  bus.an_n, bus.seg_n, bus.dp_n);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.an_n !== 8'hFF || bus.seg_n !== 7'h7F || bus.dp_n !== 1'b1) begin
         n_err++;
         $display("FAIL async_reset: an_n=%h seg_n=%h dp_n=%b, need FF 7F 1",
                  bus.an_n, bus.seg_n, bus.dp_n);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      while (cyc <= 2) begin
         logic [7:0] ea;
         ea = (cyc == 2) ? 8'hFE : 8'hFF;
         n_vec++;
         if (bus.an_n !== ea) begin
            n_err++;
            $display("FAIL restart c%0d: an_n=%h need %h", cyc, bus.an_n, ea);
         end
         step();
      end
   endtask

   task automatic test_hex_af();
      logic [6:0] exp_tab [6] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      bus.value    = 32'h00FEDCBA;
      bus.digit_en = 8'h3F;
      bus.dots     = 8'h00;
      do_reset();
      while (cyc < 48) begin
         int d, ph;
         d  = cyc / 6;
         ph = cyc % 6;
         if (ph == 3) begin
            logic [7:0] ea;
            logic [6:0] es;
            ea = 8'hFF;
            es = 7'h7F;
            if (d < 6) begin
               ea[d] = 1'b0;
               es    = exp_tab[d];
            end
            n_vec++;
            if (bus.an_n !== ea || bus.seg_n !== es) begin
               n_err++;
               $display("FAIL hex_af d%0d: an_n=%h seg_n=%h, need %h %h",
                        d, bus.an_n, bus.seg_n, ea, es);
            end
         end
         step();
      end
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      cyc          = 0;
      rst_n        = 1'b1;
      bus.value    = '0;
      bus.digit_en = '0;
      bus.dots     = '0;
      test_reset();
      test_full_frame();
      test_enables();
      test_no_tear();
      test_mid_reset();
      test_hex_af();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
